// File: rtl/exec_muldiv_if.sv
// Execute-stage bundle between the decode/execute pipeline registers and the
// iterative multiply/divide unit, including the result path into the memory stage.
interface exec_muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            write_reg;
   logic [4:0]      dst_addr;
   logic            flush;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] mul_result;
   logic            w_reg;
   logic [4:0]      dst_addrE;

   modport master (
      output start, funct3, rs1, rs2, write_reg, dst_addr, flush,
      input  stall, done, mul_result, w_reg, dst_addrE
   );

   modport slave (
      input  start, funct3, rs1, rs2, write_reg, dst_addr, flush,
      output stall, done, mul_result, w_reg, dst_addrE
   );
endinterface

// File: rtl/exec_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring
// divide, one sign-fix cycle, registered result toward the memory stage.
//
// state | meaning
// IDLE  | waiting for start; latches operands, special cases jump to DONE
// CALC  | 32 radix-2 steps, counter 0..31
// FIX   | sign correction and high/low selection
// DONE  | result presented for one cycle, then back to IDLE
module exec_muldiv #(
   parameter int XLEN = 32
) (
   input logic          clk,
   input logic          rst,
   exec_muldiv_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state;
   logic [4:0]      cnt;
   logic [2:0]      f3_q;
   logic            wr_q;
   logic [4:0]      dst_q;
   logic            a_neg_q;
   logic            neg_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] lo;

   logic            done_r;
   logic            w_reg_r;
   logic [4:0]      dst_r;
   logic [XLEN-1:0] result_r;

   logic            sgn_a_op;
   logic            sgn_b_op;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] special_val;
   logic            accept;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   fix_result;

   always_comb begin
      sgn_a_op = 1'b0;
      sgn_b_op = 1'b0;
      case (bus.funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            sgn_a_op = 1'b1;
            sgn_b_op = 1'b1;
         end
         3'b010:  sgn_a_op = 1'b1;
         default: ;
      endcase
   end

   assign a_neg  = sgn_a_op & bus.rs1[XLEN-1];
   assign b_neg  = sgn_b_op & bus.rs2[XLEN-1];
   assign a_mag  = a_neg ? -bus.rs1 : bus.rs1;
   assign b_mag  = b_neg ? -bus.rs2 : bus.rs2;
   assign accept = (state == IDLE) & bus.start & ~bus.flush;

   assign div_zero = bus.funct3[2] & (bus.rs2 == '0);
   assign div_ovf  = bus.funct3[2] & ~bus.funct3[0] & (bus.rs1 == INT_MIN) & (bus.rs2 == '1);

   // funct3[1] distinguishes REM/REMU from DIV/DIVU
   always_comb begin
      if (div_zero) special_val = bus.funct3[1] ? bus.rs1 : '1;
      else          special_val = bus.funct3[1] ? '0 : INT_MIN;
   end

   // acc/lo are shared: product high/low for multiply, remainder/quotient for divide
   assign mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, a_q} : '0);
   assign div_shift = {acc, lo[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, b_q};
   assign prod      = neg_q ? -{acc, lo} : {acc, lo};

   always_comb begin
      case (f3_q)
         3'b000:         fix_result = prod[XLEN-1:0];
         3'b001, 3'b010,
         3'b011:         fix_result = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101: fix_result = neg_q ? -lo : lo;
         default:        fix_result = a_neg_q ? -acc : acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         f3_q     <= '0;
         wr_q     <= 1'b0;
         dst_q    <= '0;
         a_neg_q  <= 1'b0;
         neg_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         lo       <= '0;
         done_r   <= 1'b0;
         w_reg_r  <= 1'b0;
         dst_r    <= '0;
         result_r <= '0;
      end else begin
         done_r  <= 1'b0;
         w_reg_r <= 1'b0;
         dst_r   <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  f3_q    <= bus.funct3;
                  wr_q    <= bus.write_reg;
                  dst_q   <= bus.dst_addr;
                  a_neg_q <= a_neg;
                  neg_q   <= a_neg ^ b_neg;
                  a_q     <= a_mag;
                  b_q     <= b_mag;
                  acc     <= '0;
                  lo      <= bus.funct3[2] ? a_mag : b_mag;
                  cnt     <= '0;
                  if (div_zero || div_ovf) begin
                     state    <= DONE;
                     done_r   <= 1'b1;
                     w_reg_r  <= bus.write_reg;
                     dst_r    <= bus.dst_addr;
                     result_r <= special_val;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (bus.flush) begin
                  state <= IDLE;
               end else begin
                  if (f3_q[2]) begin
                     if (!div_diff[XLEN]) begin
                        acc <= div_diff[XLEN-1:0];
                        lo  <= {lo[XLEN-2:0], 1'b1};
                     end else begin
                        acc <= div_shift[XLEN-1:0];
                        lo  <= {lo[XLEN-2:0], 1'b0};
                     end
                  end else begin
                     acc <= mul_sum[XLEN:1];
                     lo  <= {mul_sum[0], lo[XLEN-1:1]};
                  end
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd31) state <= FIX;
               end
            end
            FIX: begin
               if (bus.flush) begin
                  state <= IDLE;
               end else begin
                  state    <= DONE;
                  done_r   <= 1'b1;
                  w_reg_r  <= wr_q;
                  dst_r    <= dst_q;
                  result_r <= fix_result;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stall      = accept | (state == CALC) | (state == FIX);
   assign bus.done       = done_r;
   assign bus.w_reg      = w_reg_r;
   assign bus.dst_addrE  = dst_r;
   assign bus.mul_result = result_r;
endmodule
